// File: rtl/tof_i2c_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// tof_i2c_bus_arbiter_if
// Bundle of the requester-side command lanes, the shared I2C master handshake
// and the arbiter status outputs.
//   slave  : arbiter view (requester lanes and master status in; muxed command,
//            grant and routed status out)
//   master : environment view (requesters plus shared master), the mirror image
// Lane i of a packed per-requester field lives at [W*i +: W].
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface tof_i2c_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    start_in;
    logic [N_REQ-1:0]    is_read_in;
    logic [16*N_REQ-1:0] reg_addr_in;
    logic [17*N_REQ-1:0] nb_in;
    logic [8*N_REQ-1:0]  wdata_in;
    logic                m_ready;
    logic                m_error;
    logic                m_start;
    logic                m_is_read;
    logic [15:0]         m_reg_addr;
    logic [16:0]         m_nb;
    logic [7:0]          m_wdata;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    ready_out;
    logic [N_REQ-1:0]    error_out;
    logic                busy;
    logic                timeout_evt;

    modport slave (
        input  req, start_in, is_read_in, reg_addr_in, nb_in, wdata_in,
        input  m_ready, m_error,
        output m_start, m_is_read, m_reg_addr, m_nb, m_wdata,
        output grant, ready_out, error_out, busy, timeout_evt
    );

    modport master (
        output req, start_in, is_read_in, reg_addr_in, nb_in, wdata_in,
        output m_ready, m_error,
        input  m_start, m_is_read, m_reg_addr, m_nb, m_wdata,
        input  grant, ready_out, error_out, busy, timeout_evt
    );
endinterface

// File: rtl/tof_i2c_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tof_i2c_bus_arbiter
// Shares one I2C master between N_REQ ToF sensor FSMs. Round-robin grant of
// whole bursts, muxing of the owner's command lane to the master, routing of
// master ready/error back to the owner only, and a watchdog that frees the
// bus when the master stops producing ready edges.
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   bus    : tof_i2c_bus_arbiter_if.slave (requester lanes, master handshake,
//            grant / ready_out / error_out / busy / timeout_evt)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tof_i2c_bus_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1048576
) (
    input  logic                        clk,
    input  logic                        reset,
    tof_i2c_bus_arbiter_if.slave        bus
);

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // wd_cnt never exceeds TIMEOUT-1: the bus is released at that value
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int ADDR_W = 16;
    localparam int NB_W   = 17;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_r;
    logic [N_REQ-1:0]    grant_r;
    logic [PTR_W-1:0]    owner_r;
    logic [PTR_W-1:0]    rr_ptr_r;
    logic [N_REQ-1:0]    lockout_r;
    logic [WD_W-1:0]     wd_cnt_r;
    logic                m_ready_d_r;
    logic [ADDR_W-1:0]   hold_addr_r;
    logic [NB_W-1:0]     hold_nb_r;
    logic [DATA_W-1:0]   hold_wdata_r;

    logic [N_REQ-1:0]    eligible_s;
    logic                arb_found_s;
    logic [PTR_W-1:0]    arb_idx_s;
    logic [PTR_W-1:0]    rr_next_s;
    logic                ready_rise_s;
    logic                wd_expire_s;
    logic [ADDR_W-1:0]   live_addr_s;
    logic [NB_W-1:0]     live_nb_s;
    logic [DATA_W-1:0]   live_wdata_s;

    function automatic logic [N_REQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign eligible_s   = bus.req & ~lockout_r;
    assign ready_rise_s = bus.m_ready & ~m_ready_d_r;
    assign wd_expire_s  = (state_r == ST_OWNED) && (wd_cnt_r == WD_W'(TIMEOUT - 1));
    assign live_addr_s  = bus.reg_addr_in[owner_r*ADDR_W +: ADDR_W];
    assign live_nb_s    = bus.nb_in[owner_r*NB_W +: NB_W];
    assign live_wdata_s = bus.wdata_in[owner_r*DATA_W +: DATA_W];

    // Round-robin search: first eligible index starting at rr_ptr, wrapping.
    always_comb begin
        int unsigned      cand;
        logic [PTR_W-1:0] cand_idx;
        logic             hit;
        arb_found_s = 1'b0;
        arb_idx_s   = '0;
        cand        = 32'd0;
        cand_idx    = '0;
        hit         = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand        = 32'(rr_ptr_r) + k;
            cand        = (cand >= 32'(N_REQ)) ? (cand - 32'(N_REQ)) : cand;
            cand_idx    = PTR_W'(cand);
            hit         = !arb_found_s && eligible_s[cand_idx];
            arb_idx_s   = hit ? cand_idx : arb_idx_s;
            arb_found_s = arb_found_s | hit;
        end
    end

    // Pointer moves past the winner so it has lowest priority next round.
    always_comb begin
        int unsigned nxt;
        nxt       = 32'(arb_idx_s) + 32'd1;
        nxt       = (nxt >= 32'(N_REQ)) ? 32'd0 : nxt;
        rr_next_s = PTR_W'(nxt);
    end

    // Arbitration FSM, watchdog, lockout and held command fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            owner_r      <= '0;
            rr_ptr_r     <= '0;
            lockout_r    <= '0;
            wd_cnt_r     <= '0;
            m_ready_d_r  <= 1'b0;
            hold_addr_r  <= '0;
            hold_nb_r    <= '0;
            hold_wdata_r <= '0;
        end else begin
            m_ready_d_r <= bus.m_ready;
            // A lockout lasts only while its requester keeps req asserted
            lockout_r   <= lockout_r & bus.req;
            if (state_r != ST_IDLE) begin
                hold_addr_r  <= live_addr_s;
                hold_nb_r    <= live_nb_s;
                hold_wdata_r <= live_wdata_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (arb_found_s) begin
                        state_r  <= ST_OWNED;
                        grant_r  <= to_onehot(arb_idx_s);
                        owner_r  <= arb_idx_s;
                        rr_ptr_r <= rr_next_s;
                        wd_cnt_r <= '0;
                    end
                end
                ST_OWNED: begin
                    // Expiry beats a simultaneous normal release
                    if (wd_expire_s) begin
                        state_r   <= ST_DRAIN;
                        lockout_r <= (lockout_r & bus.req) | grant_r;
                    end else if (!bus.req[owner_r]) begin
                        state_r <= ST_DRAIN;
                    end else if (ready_rise_s) begin
                        wd_cnt_r <= '0;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_W'(1);
                    end
                end
                ST_DRAIN: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

    // Output mux: owner's lane while owned, start suppressed in DRAIN,
    // last owner's address/count/data held while the bus is free.
    always_comb begin
        bus.m_start     = 1'b0;
        bus.m_is_read   = 1'b0;
        bus.m_reg_addr  = hold_addr_r;
        bus.m_nb        = hold_nb_r;
        bus.m_wdata     = hold_wdata_r;
        bus.ready_out   = '0;
        bus.error_out   = '0;
        bus.timeout_evt = 1'b0;
        case (state_r)
            ST_OWNED: begin
                bus.m_start     = bus.start_in[owner_r];
                bus.m_is_read   = bus.is_read_in[owner_r];
                bus.m_reg_addr  = live_addr_s;
                bus.m_nb        = live_nb_s;
                bus.m_wdata     = live_wdata_s;
                bus.ready_out   = grant_r & {N_REQ{bus.m_ready}};
                bus.error_out   = grant_r & {N_REQ{bus.m_error | wd_expire_s}};
                bus.timeout_evt = wd_expire_s;
            end
            ST_DRAIN: begin
                bus.m_is_read  = bus.is_read_in[owner_r];
                bus.m_reg_addr = live_addr_s;
                bus.m_nb       = live_nb_s;
                bus.m_wdata    = live_wdata_s;
            end
            default: begin
                bus.m_start = 1'b0;
            end
        endcase
    end

    assign bus.grant = grant_r;
    assign bus.busy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_tof_i2c_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tof_i2c_bus_arbiter
// Directed scenarios with hand-computed expectations, then randomized traffic.
// A cycle-level behavioural model (integer owner, round-robin pointer, lock
// flags, quiet-cycle counter) predicts every output each cycle.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tof_i2c_bus_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;

    tof_i2c_bus_arbiter_if #(.N_REQ(N)) bus ();

    tof_i2c_bus_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          mo_owner;   // -1 when nobody holds the bus
    bit          mo_drain;   // owner has released, one hand-back cycle
    int          mo_rr;
    bit          mo_lock [N];
    int          mo_quiet;   // owned cycles since the last ready edge
    bit          mo_prev_ready;
    logic [15:0] mo_addr;
    logic [16:0] mo_nb;
    logic [7:0]  mo_wd;

    task automatic model_reset();
        mo_owner = -1; mo_drain = 1'b0; mo_rr = 0; mo_quiet = 0; mo_prev_ready = 1'b0;
        mo_addr = 16'h0; mo_nb = 17'h0; mo_wd = 8'h0;
        for (int i = 0; i < N; i++) mo_lock[i] = 1'b0;
    endtask

    task automatic model_step();
        int o;
        int idx;
        bit timed_out;
        bit found;
        o = mo_owner; timed_out = 1'b0; found = 1'b0;
        if (o >= 0) begin
            mo_addr = bus.reg_addr_in[16*o +: 16];
            mo_nb   = bus.nb_in[17*o +: 17];
            mo_wd   = bus.wdata_in[8*o +: 8];
        end
        if (o < 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (mo_rr + k) % N;
                if (!found && bus.req[idx] && !mo_lock[idx]) begin
                    found = 1'b1; mo_owner = idx; mo_drain = 1'b0;
                    mo_quiet = 0; mo_rr = (idx + 1) % N;
                end
            end
        end else if (mo_drain) begin
            mo_owner = -1; mo_drain = 1'b0;
        end else if (mo_quiet == TO - 1) begin
            timed_out = 1'b1; mo_drain = 1'b1;
        end else if (!bus.req[o]) begin
            mo_drain = 1'b1;
        end else if (bus.m_ready && !mo_prev_ready) begin
            mo_quiet = 0;
        end else begin
            mo_quiet++;
        end
        for (int i = 0; i < N; i++) mo_lock[i] = mo_lock[i] && bus.req[i];
        if (timed_out) mo_lock[o] = 1'b1;
        mo_prev_ready = bus.m_ready;
    endtask

    task automatic compare_outputs();
        logic         e_start, e_rd, e_busy, e_tevt;
        logic [15:0]  e_addr;
        logic [16:0]  e_nb;
        logic [7:0]   e_wd;
        logic [N-1:0] e_g, e_r, e_e, one;
        one = 4'b0001;
        e_start = 1'b0; e_rd = 1'b0; e_busy = 1'b0; e_tevt = 1'b0;
        e_addr = mo_addr; e_nb = mo_nb; e_wd = mo_wd;
        e_g = 4'b0000; e_r = 4'b0000; e_e = 4'b0000;
        if (mo_owner >= 0) begin
            e_g    = one << mo_owner;
            e_busy = 1'b1;
            e_rd   = bus.is_read_in[mo_owner];
            e_addr = bus.reg_addr_in[16*mo_owner +: 16];
            e_nb   = bus.nb_in[17*mo_owner +: 17];
            e_wd   = bus.wdata_in[8*mo_owner +: 8];
            if (!mo_drain) begin
                e_start = bus.start_in[mo_owner];
                e_tevt  = (mo_quiet == TO - 1);
                if (bus.m_ready) e_r = e_g;
                if (bus.m_error || e_tevt) e_e = e_g;
            end
        end
        check("m_start", bus.m_start, e_start);
        check("m_is_read", bus.m_is_read, e_rd);
        check("m_reg_addr", bus.m_reg_addr, e_addr);
        check("m_nb", bus.m_nb, e_nb);
        check("m_wdata", bus.m_wdata, e_wd);
        check("grant", bus.grant, e_g);
        check("ready_out", bus.ready_out, e_r);
        check("error_out", bus.error_out, e_e);
        check("busy", bus.busy, e_busy);
        check("timeout_evt", bus.timeout_evt, e_tevt);
    endtask

    // Single compare process: check mid-cycle, advance the model on the edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            #2;
            if (reset) model_reset();
            compare_outputs();
            @(posedge clk);
            if (reset) model_reset();
            else model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) cyc();
    endtask

    task automatic wait_grant(input int max_cyc, output int waited, output int idx);
        waited = 0; idx = -1;
        while (idx < 0 && waited < max_cyc) begin
            cyc(); #3; waited++;
            for (int i = 0; i < N; i++) if (bus.grant[i]) idx = i;
        end
        if (idx < 0) begin
            checks++; errors++;
            $display("FAIL wait_grant: no grant within %0d cycles at %0t", max_cyc, $time);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w, g, fired, stuck;
        reset = 1'b1;
        bus.req = 4'b0; bus.start_in = 4'b0; bus.is_read_in = 4'b0;
        bus.reg_addr_in = 64'h0; bus.nb_in = 68'h0; bus.wdata_in = 32'h0;
        bus.m_ready = 1'b0; bus.m_error = 1'b0;
        cyc(); #3;
        check("rst_grant", bus.grant, 4'b0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_addr", bus.m_reg_addr, 16'h0000);
        settle(2);
        reset = 1'b0;

        // 1: single request from lane 1
        cyc();
        bus.reg_addr_in = 64'h1111_2222_BEEF_3333;
        bus.start_in = 4'b1111; bus.req = 4'b0010; #3;
        check("t1_not_yet", bus.grant, 4'b0000);
        cyc(); #3;
        check("t1_grant", bus.grant, 4'b0010);
        check("t1_addr", bus.m_reg_addr, 16'hBEEF);
        check("t1_start", bus.m_start, 1'b1);
        cyc(); bus.req = 4'b0000; #3;
        check("t1_still_owned", bus.grant, 4'b0010);
        cyc(); #3;
        check("t1_drain_grant", bus.grant, 4'b0010);
        check("t1_drain_start", bus.m_start, 1'b0);
        check("t1_drain_busy", bus.busy, 1'b1);
        cyc(); #3;
        check("t1_free", bus.grant, 4'b0000);
        check("t1_held_addr", bus.m_reg_addr, 16'hBEEF);

        // 3: lane 2 owns while lane 0 pulses
        cyc(); bus.req = 4'b0100; bus.start_in = 4'b0001;
        wait_grant(4, w, g);
        check("t3_owner", g, 2);
        for (int k = 0; k < 8; k++) begin
            cyc();
            bus.req     = (k % 2 == 1) ? 4'b0101 : 4'b0100;
            bus.m_ready = (k % 2 == 1);
            bus.m_error = (k % 4 >= 2);
            #3;
            check("t3_ready", bus.ready_out, (k % 2 == 1) ? 4'b0100 : 4'b0000);
            check("t3_error", bus.error_out, (k % 4 >= 2) ? 4'b0100 : 4'b0000);
            check("t3_start", bus.m_start, 1'b0);
        end
        cyc(); bus.req = 4'b0000; bus.m_ready = 1'b0; bus.m_error = 1'b0;
        settle(2);

        // 4: watchdog on lane 3 with m_ready stuck low
        cyc(); bus.req = 4'b1000;
        wait_grant(4, w, g);
        check("t4_owner", g, 3);
        fired = -1;
        for (int c = 1; c < 40 && fired < 0; c++) begin
            cyc(); #3;
            if (bus.timeout_evt) begin
                fired = c;
                check("t4_error3", bus.error_out, 4'b1000);
            end
        end
        check("t4_expiry_cycle", fired, 15);
        cyc(); #3;
        check("t4_drain", bus.grant, 4'b1000);
        for (int k = 0; k < 6; k++) begin
            cyc(); #3;
            check("t4_locked", bus.grant, 4'b0000);
        end
        cyc(); bus.req = 4'b0000;
        cyc(); bus.req = 4'b1000; #3;
        check("t4_relock_idle", bus.grant, 4'b0000);
        cyc(); #3;
        check("t4_regrant", bus.grant, 4'b1000);
        cyc(); bus.req = 4'b0000;
        settle(2);

        // 6: release and expiry in the same cycle on lane 0
        cyc(); bus.req = 4'b0001;
        wait_grant(4, w, g);
        check("t6_owner", g, 0);
        for (int c = 1; c < 15; c++) cyc();
        cyc(); bus.req = 4'b0000; #3;
        check("t6_tevt", bus.timeout_evt, 1'b1);
        check("t6_error", bus.error_out, 4'b0001);
        cyc(); bus.req = 4'b0001; #3;
        check("t6_drain", bus.grant, 4'b0001);
        cyc(); #3;
        check("t6_idle", bus.grant, 4'b0000);
        cyc(); #3;
        check("t6_lockout_holds", bus.grant, 4'b0000);
        cyc(); bus.req = 4'b0000;
        settle(2);

        // 5: async reset mid-burst
        cyc(); bus.req = 4'b0010; bus.start_in = 4'b1111;
        bus.reg_addr_in = 64'hAAAA_BBBB_CCCC_DDDD;
        wait_grant(4, w, g);
        check("t5_owner", g, 1);
        check("t5_start_hi", bus.m_start, 1'b1);
        cyc(); #1; reset = 1'b1; #1;
        check("t5_start", bus.m_start, 1'b0);
        check("t5_grant", bus.grant, 4'b0000);
        check("t5_busy", bus.busy, 1'b0);
        check("t5_addr", bus.m_reg_addr, 16'h0000);
        bus.req = 4'b0000;
        cyc(); cyc(); reset = 1'b0;

        // 2: all four requesting, each releasing after three ready pulses
        cyc(); bus.req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            wait_grant(6, w, g);
            if (g >= 0) begin
                check("t2_order", g, r % 4);
                if (r > 0) check("t2_gap", w, 2);
                for (int p = 0; p < 3; p++) begin
                    cyc(); bus.m_ready = 1'b1;
                    cyc(); bus.m_ready = 1'b0;
                end
                if (r < 4) begin
                    cyc(); bus.req[g] = 1'b0;
                    cyc(); bus.req[g] = 1'b1;
                end
            end
        end
        cyc(); bus.req = 4'b0000;
        settle(2);

        // Randomized traffic
        stuck = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 499) == 0) reset = 1'b1;
            for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) bus.req[i] = ~bus.req[i];
            bus.start_in    = 4'($urandom);
            bus.is_read_in  = 4'($urandom);
            bus.reg_addr_in = {$urandom, $urandom};
            bus.nb_in       = 68'({$urandom, $urandom, $urandom});
            bus.wdata_in    = $urandom;
            if (stuck > 0) begin
                stuck--;
                bus.m_ready = 1'b0;
            end else begin
                bus.m_ready = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 99) == 0) stuck = 30;
            end
            bus.m_error = ($urandom_range(0, 15) == 0);
        end
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
